// File: rtl/nvdla_dbb_rd_engine.sv
// -----------------------------------------------------------------------------
// nvdla_dbb_rd_engine
//
// Burst read engine. It accepts one burst request (start address, len, id),
// issues len+1 single-beat reads to a request/grant memory port, collects the
// in-order responses in a small buffer, and streams them out on a valid/ready
// read-data port tagged with the burst id and a last flag.
//
// The engine only issues a beat while inflight + buffered < FIFO_DEPTH. Every
// granted beat therefore already has a buffer slot reserved, so the response
// side never has to apply backpressure to memory.
//
// Ports
//   clk_i, rst_ni, clear_i     clock, async active-low reset, sync clear
//   req_valid_i/req_ready_o    burst request handshake
//   req_addr_i/len_i/id_i      burst start byte address, beats-1, id
//   mem_req_o/mem_gnt_i        memory read request / grant
//   mem_addr_o                 byte address of the requested beat
//   mem_r_valid_i/r_data_i     in-order read response
//   rdat_valid_o/rdat_ready_i  read-data handshake
//   rdat_data_o/last_o/id_o    read-data beat, last-beat flag, burst id
//   busy_o                     high whenever a burst is being processed
// -----------------------------------------------------------------------------
module nvdla_dbb_rd_engine #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 4,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [ID_W-1:0]   req_id_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_r_valid_i,
  input  logic [DATA_W-1:0] mem_r_data_i,
  output logic              rdat_valid_o,
  input  logic              rdat_ready_i,
  output logic [DATA_W-1:0] rdat_data_o,
  output logic              rdat_last_o,
  output logic [ID_W-1:0]   rdat_id_o,
  output logic              busy_o
);

  localparam int BYTES  = DATA_W / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  // One extra bit so that len = 2^LEN_W-1 still gives a representable count.
  localparam int BEAT_W = LEN_W + 1;

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   left_q, left_d;      // beats still to be granted
  logic [BEAT_W-1:0]   total_q, total_d;    // len+1 of the current burst
  logic [BEAT_W-1:0]   popped_q, popped_d;  // beats already handed off
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic credit_ok;
  logic gnt;
  logic push;
  logic pop;
  logic last_beat;

  // ---------------------------------------------------------------------------
  // Handshake and output decode (all driven from flops only)
  // ---------------------------------------------------------------------------
  // The credit sum only drops without a grant (responses move a beat from
  // inflight to buffered, pops remove one), so a raised mem_req_o stays up
  // until it is granted.
  assign credit_ok   = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
  assign mem_req_o   = (state_q == ISSUE) && credit_ok;
  assign mem_addr_o  = addr_q;
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

  assign gnt  = mem_req_o && mem_gnt_i;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign push = mem_r_valid_i && (inflight_q != '0);

  assign rdat_valid_o = (count_q != '0);
  assign pop          = rdat_valid_o && rdat_ready_i;
  assign last_beat    = ((popped_q + BEAT_W'(1)) == total_q);

  // Gating with valid keeps the outputs at zero while empty without having to
  // reset the storage array.
  assign rdat_data_o = rdat_valid_o ? fifo_mem[rd_ptr_q] : '0;
  assign rdat_last_o = rdat_valid_o && last_beat;
  assign rdat_id_o   = rdat_valid_o ? id_q : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    total_d    = total_q;
    popped_d   = popped_q;
    id_d       = id_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          left_d   = {1'b0, req_len_i} + BEAT_W'(1);
          total_d  = {1'b0, req_len_i} + BEAT_W'(1);
          popped_d = '0;
          id_d     = req_id_i;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (gnt) begin
          addr_d = addr_q + ADDR_W'(BYTES);
          left_d = left_q - BEAT_W'(1);
          if (left_q == BEAT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last beat can only leave once everything before it has, so its
        // pop implies nothing is inflight or buffered afterwards.
        if (pop && rdat_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case ({gnt, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: ;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      popped_d = popped_q + BEAT_W'(1);
    end

    // Clear abandons any burst and wins over every other input.
    if (clear_i) begin
      state_d    = IDLE;
      addr_d     = '0;
      left_d     = '0;
      total_d    = '0;
      popped_d   = '0;
      id_d       = '0;
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      total_q    <= '0;
      popped_q   <= '0;
      id_q       <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle regardless of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      total_q    <= total_d;
      popped_q   <= popped_d;
      id_q       <= id_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: the data array has no reset; occupancy is tracked by count_q and the
  // outputs are gated with valid, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_r_data_i;
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni || clear_i)
      !(push && (count_q == CNT_W'(FIFO_DEPTH))))
    else $error("response pushed into a full buffer");

  a_no_stray_rsp: assert property (
    @(posedge clk_i) disable iff (!rst_ni || clear_i)
      !(mem_r_valid_i && (inflight_q == '0)))
    else $error("read response with no beat outstanding");

endmodule
